// File: rtl/smi_stream_arb.sv
// rtl/smi_stream_arb.sv - round-robin RX FIFO arbiter serialising words into an 8-bit SMI byte stream
// Optional per-grant header byte when SMI_STREAM_TAG_EN is defined.
module smi_stream_arb #(
  parameter int NUM_CH    = 2,
  parameter int WORD_W    = 32,
  parameter int BURST_LEN = 16
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst_b,
  input  logic                     i_enable,
  input  logic [NUM_CH-1:0]        i_ch_mask,
  input  logic [NUM_CH-1:0]        i_fifo_empty,
  output logic [NUM_CH-1:0]        o_fifo_pull,
  input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
  output logic                     o_byte_valid,
  input  logic                     i_byte_ready,
  output logic [7:0]               o_byte_data,
  output logic [2:0]               o_ch_id,
  output logic                     o_sow,
  output logic                     o_busy
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_HDR   = 3'd2,
    S_PULL  = 3'd3,
    S_LOAD  = 3'd4,
    S_SHIFT = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         grant;
  logic [2:0]         last_grant;
  logic [CNT_W-1:0]   burst_cnt;
  logic [CNT_W-1:0]   burst_inc;
  logic [WORD_W-1:0]  shreg;
  logic [IDX_W-1:0]   byte_idx;

  logic [NUM_CH-1:0]  cand;
  logic [NUM_CH-1:0]  grant_oh;
  logic               grant_ready;
  logic               grant_empty;
  logic [WORD_W-1:0]  grant_word;
  logic               arb_found;
  logic [2:0]         arb_pick;
  int                 arb_idx;
  logic               byte_last;
  logic               xfer;
  logic               burst_more;

  assign cand        = i_ch_mask & ~i_fifo_empty;
  assign grant_oh    = CH_ONE << grant;
  assign grant_ready = |(cand & grant_oh);
  assign grant_empty = |(i_fifo_empty & grant_oh);
  assign grant_word  = WORD_W'(i_fifo_data >> (int'(grant) * WORD_W));
  assign byte_last   = (byte_idx == IDX_W'(BYTES - 1));
  assign xfer        = o_byte_valid && i_byte_ready;
  assign burst_inc   = burst_cnt + 1'b1;
  assign burst_more  = (burst_inc < CNT_W'(BURST_LEN));

  // Rotating priority: search upward from the channel after the last grant.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = 3'd0;
    arb_idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      arb_idx = (int'(last_grant) + i) % NUM_CH;
      if (!arb_found && |(cand & (CH_ONE << arb_idx))) begin
        arb_found = 1'b1;
        arb_pick  = 3'(arb_idx);
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_enable) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (!i_enable) begin
          state_nxt = S_IDLE;
        end else if (arb_found) begin
`ifdef SMI_STREAM_TAG_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_PULL;
`endif
        end
      end
`ifdef SMI_STREAM_TAG_EN
      S_HDR: begin
        if (xfer) state_nxt = S_PULL;
      end
`endif
      // A FIFO that drained since arbitration is never pulled; re-arbitrate instead.
      S_PULL: begin
        if (grant_empty) state_nxt = i_enable ? S_ARB : S_IDLE;
        else             state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (xfer && byte_last) begin
          if (i_enable && grant_ready && burst_more) state_nxt = S_PULL;
          else if (i_enable)                         state_nxt = S_ARB;
          else                                       state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      grant      <= 3'd0;
      last_grant <= 3'(NUM_CH - 1);
      burst_cnt  <= '0;
      shreg      <= '0;
      byte_idx   <= '0;
    end else begin
      if (state == S_ARB && i_enable && arb_found) begin
        grant      <= arb_pick;
        last_grant <= arb_pick;
        burst_cnt  <= '0;
      end
      if (state == S_LOAD) begin
        shreg    <= grant_word;
        byte_idx <= '0;
      end
      // Shift only on handshake so the presented byte holds under backpressure.
      if (state == S_SHIFT && xfer) begin
        shreg <= shreg << 8;
        if (byte_last) begin
          byte_idx  <= '0;
          burst_cnt <= burst_inc;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_fifo_pull  = '0;
    o_byte_valid = 1'b0;
    o_byte_data  = 8'h00;
    o_ch_id      = 3'd0;
    o_sow        = 1'b0;
    o_busy       = (state != S_IDLE);
    case (state)
`ifdef SMI_STREAM_TAG_EN
      S_HDR: begin
        o_byte_valid = 1'b1;
        o_byte_data  = {4'hA, 1'b0, grant};
        o_ch_id      = grant;
      end
`endif
      S_PULL: begin
        o_fifo_pull = grant_empty ? '0 : grant_oh;
      end
      S_SHIFT: begin
        o_byte_valid = 1'b1;
        o_byte_data  = shreg[WORD_W-1 -: 8];
        o_ch_id      = grant;
        o_sow        = (byte_idx == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smi_stream_arb.sv
// tb/tb_smi_stream_arb.sv - directed self-checking bench for smi_stream_arb
// Expects header bytes when SMI_STREAM_TAG_EN is defined.
module tb_smi_stream_arb;

  localparam int NUM_CH    = 2;
  localparam int WORD_W    = 32;
  localparam int BURST_LEN = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        enable;
  logic [1:0]  mask;
  logic [1:0]  fifo_empty;
  logic [1:0]  pull;
  logic        valid;
  logic        ready;
  logic [7:0]  data;
  logic [2:0]  ch_id;
  logic        sow;
  logic        busy;

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  int          wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  logic [31:0] d0 = '0, d1 = '0;

  int n_chk = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  int pulls0 = 0;

  always #5 clk = ~clk;

  assign fifo_empty[0] = (wp0 == rp0);
  assign fifo_empty[1] = (wp1 == rp1);

  smi_stream_arb #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .BURST_LEN(BURST_LEN)) dut (
    .i_sys_clk    (clk),
    .i_rst_b      (rst_b),
    .i_enable     (enable),
    .i_ch_mask    (mask),
    .i_fifo_empty (fifo_empty),
    .o_fifo_pull  (pull),
    .i_fifo_data  ({d1, d0}),
    .o_byte_valid (valid),
    .i_byte_ready (ready),
    .o_byte_data  (data),
    .o_ch_id      (ch_id),
    .o_sow        (sow),
    .o_busy       (busy)
  );

  // FIFO read side: data appears one cycle after the pull strobe.
  always @(posedge clk) begin
    if (pull[0] && wp0 != rp0) begin
      d0  <= mem0[rp0];
      rp0 <= rp0 + 1;
    end
    if (pull[1] && wp1 != rp1) begin
      d1  <= mem1[rp1];
      rp1 <= rp1 + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      n_chk++;
      assert ($onehot0(pull)) else begin
        n_fail++;
        $error("FAIL pull_onehot: observed %b expected at most one bit", pull);
      end
      n_chk++;
      assert ((pull & fifo_empty) === 2'b00) else begin
        n_fail++;
        $error("FAIL pull_on_empty: observed pull %b empty %b expected no overlap", pull, fifo_empty);
      end
      if (valid && ready) xfer_cnt++;
      if (pull[0]) pulls0++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[wp0] = w;
    wp0 = wp0 + 1;
  endtask

  task automatic push1(input logic [31:0] w);
    mem1[wp1] = w;
    wp1 = wp1 + 1;
  endtask

  task automatic get_byte(output logic [7:0] b, output logic [2:0] c, output logic s);
    bit got;
    got = 1'b0;
    b = 8'h00;
    c = 3'd0;
    s = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (valid && ready) begin
        b = data;
        c = ch_id;
        s = sow;
        got = 1'b1;
      end
      tick();
    end
    if (!got) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] eb, input logic [2:0] ec, input logic es);
    logic [7:0] b;
    logic [2:0] c;
    logic       s;
    get_byte(b, c, s);
    check({tag, "_data"}, 32'(b), 32'(eb));
    check({tag, "_ch"},   32'(c), 32'(ec));
    check({tag, "_sow"},  32'(s), 32'(es));
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w, input logic [2:0] c);
    for (int i = 0; i < 4; i++) begin
      expect_byte(tag, w[31-8*i -: 8], c, (i == 0));
    end
  endtask

  task automatic expect_hdr(input logic [2:0] c);
`ifdef SMI_STREAM_TAG_EN
    expect_byte("hdr", {4'hA, 1'b0, c}, c, 1'b0);
`endif
  endtask

  task automatic do_reset();
    rst_b  = 1'b0;
    enable = 1'b0;
    mask   = 2'b00;
    ready  = 1'b0;
    wp0 = rp0;
    wp1 = rp1;
    tick();
    tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_pull",  32'(pull),  32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_sow",   32'(sow),   32'd0);
    check("rst_ch",    32'(ch_id), 32'd0);
    rst_b = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rr_word(input int c, input int i);
    return {4'(c), 4'(i), 8'h5A, 8'(c * 16 + i), 8'hC3};
  endfunction

  initial begin
    bit          seen;
    int          idx0, idx1, x0, p0;
    logic [2:0]  order [8];

    // Single channel word with latency check.
    do_reset();
    mask = 2'b11;
    push0(32'h11223344);
    ready  = 1'b1;
    enable = 1'b1;
    expect_hdr(3'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (pull != 2'b00) seen = 1'b1;
      else tick();
    end
    check("pull_seen", 32'(pull), 32'h1);
    check("pull_valid", 32'(valid), 32'd0);
    tick();
    check("pull_one_cycle", 32'(pull), 32'd0);
    check("load_valid", 32'(valid), 32'd0);
    tick();
    check("lat2_valid", 32'(valid), 32'd1);
    expect_word("single", 32'h11223344, 3'd0);
    check("idle_arb_valid", 32'(valid), 32'd0);
    check("idle_arb_busy",  32'(busy),  32'd1);
    tick();
    tick();
    check("idle_arb_pull", 32'(pull), 32'd0);
    check("idle_arb_busy2", 32'(busy), 32'd1);

    // Round robin with burst limit 2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push0(rr_word(0, i));
      push1(rr_word(1, i));
    end
    order = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1};
    mask   = 2'b11;
    ready  = 1'b1;
    enable = 1'b1;
    idx0 = 0;
    idx1 = 0;
    for (int w = 0; w < 8; w++) begin
      if (w % 2 == 0) expect_hdr(order[w]);
      if (order[w] == 3'd0) begin
        expect_word("rr", rr_word(0, idx0), 3'd0);
        idx0++;
      end else begin
        expect_word("rr", rr_word(1, idx1), 3'd1);
        idx1++;
      end
    end
    check("rr_drained", 32'(fifo_empty), 32'h3);

    // Backpressure: ready 1,0,0,1 within one word.
    do_reset();
    push0(32'hDEADBEEF);
    mask   = 2'b01;
    ready  = 1'b1;
    enable = 1'b1;
    expect_hdr(3'd0);
    ready = 1'b0;
    x0 = xfer_cnt;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (valid) seen = 1'b1;
      else tick();
    end
    check("bp_b0_data", 32'(data), 32'hDE);
    check("bp_b0_sow",  32'(sow),  32'd1);
    ready = 1'b1;
    tick();
    check("bp_b1_data", 32'(data), 32'hAD);
    check("bp_b1_sow",  32'(sow),  32'd0);
    ready = 1'b0;
    tick();
    check("bp_hold1_data", 32'(data), 32'hAD);
    tick();
    check("bp_hold2_data",  32'(data),  32'hAD);
    check("bp_hold2_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    expect_byte("bp_b2", 8'hBE, 3'd0, 1'b0);
    expect_byte("bp_b3", 8'hEF, 3'd0, 1'b0);
    check("bp_after_valid", 32'(valid), 32'd0);
    check("bp_count", 32'(xfer_cnt - x0), 32'd4);

    // Mask skips ch0; enable dropped during byte 2 finishes the word.
    do_reset();
    push0(32'h01020304);
    push1(32'h55667788);
    push1(32'h99AABBCC);
    p0 = pulls0;
    mask   = 2'b10;
    ready  = 1'b1;
    enable = 1'b1;
    expect_hdr(3'd1);
    expect_byte("me_b0", 8'h55, 3'd1, 1'b1);
    enable = 1'b0;
    expect_byte("me_b1", 8'h66, 3'd1, 1'b0);
    expect_byte("me_b2", 8'h77, 3'd1, 1'b0);
    expect_byte("me_b3", 8'h88, 3'd1, 1'b0);
    check("me_valid", 32'(valid), 32'd0);
    check("me_busy",  32'(busy),  32'd0);
    tick();
    check("me_busy2", 32'(busy), 32'd0);
    check("me_no_ch0_pull", 32'(pulls0 - p0), 32'd0);
    check("me_ch1_left", 32'(wp1 - rp1), 32'd1);

    // Asynchronous reset mid-word.
    enable = 1'b1;
    expect_hdr(3'd1);
    expect_byte("rm_b0", 8'h99, 3'd1, 1'b1);
    expect_byte("rm_b1", 8'hAA, 3'd1, 1'b0);
    check("rm_pre_valid", 32'(valid), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("rm_async_valid", 32'(valid), 32'd0);
    check("rm_async_busy",  32'(busy),  32'd0);
    enable = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    mask  = 2'b11;
    push1(32'h0BADF00D);
    enable = 1'b1;
    expect_hdr(3'd0);
    expect_word("rm_next", 32'h01020304, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/smi_stream_arb.md
Name: smi_stream_arb

Overview:
- Parametrised successor to the fixed two-channel (0.9 GHz / 2.4 GHz) RX FIFO-to-SMI path.
- Round-robin arbitrates NUM_CH receive FIFOs, pulls WORD_W-bit I/Q words in bursts of up to BURST_LEN words, and serialises each word into 8-bit bytes on a valid/ready stream toward the SMI data bus.
- Sits between the per-channel complex FIFOs (read side, sys clock domain) and the SMI controller.

Parameters:
- NUM_CH, 2, number of RX channels/FIFOs (1..8).
- WORD_W, 32, FIFO word width; must be a multiple of 8.
- BURST_LEN, 16, maximum words taken from one channel per grant (1..256).

Ports:
- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_rst_b  in  1  asynchronous active-low reset.
- i_enable  in  1  streaming enable.
- i_ch_mask  in  NUM_CH  per-channel participation mask; 1 = eligible.
- i_fifo_empty  in  NUM_CH  per-channel FIFO empty flags.
- o_fifo_pull  out  NUM_CH  per-channel one-cycle read strobe.
- i_fifo_data  in  NUM_CH*WORD_W  read data, packed; channel k is at [k*WORD_W +: WORD_W]; valid 1 cycle after pull.
- o_byte_valid  out  1  output byte valid.
- i_byte_ready  in  1  consumer ready.
- o_byte_data  out  8  output byte.
- o_ch_id  out  3  channel of the current byte.
- o_sow  out  1  start-of-word; high on the first byte of each word.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = NUM_CH-1, so ch0 has first priority; burst counter 0.
- A byte transfers on a rising edge where o_byte_valid && i_byte_ready.
  - While o_byte_valid && !i_byte_ready, o_byte_data, o_ch_id and o_sow hold stable.
- State IDLE: go to ARB when i_enable = 1.
- State ARB:
  - Candidates are channels k with i_ch_mask[k] && !i_fifo_empty[k].
  - Grant the first candidate found searching upward from (last_grant+1) mod NUM_CH, with wrap-around.
  - With no candidate, stay in ARB; return to IDLE if i_enable = 0.
  - On grant: store the channel, set last_grant, clear the burst counter, go to PULL.
- State PULL: assert o_fifo_pull[grant] for exactly one cycle, then go to LOAD.
- State LOAD: capture i_fifo_data slice of grant into the shift register, then go to SHIFT.
  - Pull-to-first-byte-valid latency is 2 cycles.
- State SHIFT:
  - Present bytes MSB first: [WORD_W-1 -: 8] first, then the remaining bytes in descending order.
  - o_sow = 1 on byte 0 only; o_ch_id = grant on every byte.
  - After the last byte (WORD_W/8 transfers) is accepted, increment the burst counter.
  - Continue to PULL (same channel) only if all hold: i_enable, i_ch_mask[grant], !i_fifo_empty[grant], burst counter < BURST_LEN.
  - Otherwise go to ARB, or to IDLE if i_enable = 0.
- Back-to-back words: o_byte_valid drops for 2 cycles (PULL, LOAD) between words.
- i_enable deasserted mid-word: the current word completes; no partial words are ever emitted.
- Mask or empty changes mid-word have no effect until the next word boundary.
- o_fifo_pull is never asserted for a channel whose empty flag was high in the same cycle.
- At most one o_fifo_pull bit is high per cycle.
- Reset asserted mid-operation: immediate return to the reset state; any partially sent word is discarded.

Optional Feature:
- Macro: SMI_STREAM_TAG_EN.
- Defined: every grant emits one header byte before the first word of the burst.
  - Header value: {4'hA, 1'b0, ch[2:0]}, with o_sow = 0 and o_ch_id = grant.
  - Added state HDR between ARB and PULL; HDR waits for the handshake.
- Not defined: no header; ARB goes directly to PULL.

Test Plan:
- Single channel: NUM_CH=2, ch0 holds 0x11223344, ch1 empty, mask 2'b11, ready=1.
  - Required: bytes 11,22,33,44 with o_ch_id=0 and o_sow only on 11.
  - Required: o_fifo_pull[0] is one cycle and first valid is 2 cycles later; afterwards the block idles in ARB.
- Round robin with burst limit: BURST_LEN=2, both FIFOs hold 4 words.
  - Required channel order by word: 0,0,1,1,0,0,1,1.
- Backpressure: ready toggles 1,0,0,1 during a word.
  - Required: byte data holds stable while not ready; no byte lost or duplicated; 4 bytes total.
- Mask and enable: ch0 masked with data present, so only ch1 is served.
  - Required: dropping i_enable during byte 2 of a word completes that word (bytes 3,4 sent), then IDLE with o_busy=0.
- Reset mid-word: assert i_rst_b=0 after byte 2.
  - Required: o_byte_valid=0 asynchronously.
  - Required after release: the next grant is ch0 and the next word starts with o_sow=1.
- SMI_STREAM_TAG_EN defined, ch1 granted.
  - Required: first byte 0xA1 with o_sow=0, followed by the word bytes.
